// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single data RAM port between the MIPS core data port
// (read/write) and the VGA frame fetcher (read-only), all on clk0.
//
// Arbitration is combinational and fixed CPU-priority. A wait counter tracks
// consecutive denied VGA cycles. Once it reaches MAX_WAIT, VGA is forced ahead
// of the CPU for exactly one cycle. Read data returns one cycle after the
// grant and is routed to the requester that owned that access.
//
// Optional build macro: ARB_STATS_EN adds the o_stat_cpu_stalls and
// o_stat_vga_forced counters. Arbitration behaves the same whether or not the
// macro is defined.
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_cpu_req/we/addr/sel/wdata  CPU access request
//   o_cpu_rdata, o_cpu_stall   CPU read data (1 cycle late), request not granted
//   i_vga_req, i_vga_addr      VGA read request
//   o_vga_gnt                  VGA request accepted this cycle
//   o_vga_rdata, o_vga_rvalid  VGA read data (held), valid the cycle after grant
//   o_ram_en/we/addr/sel/wdata RAM port drive
//   i_ram_rdata                RAM read data, valid 1 cycle after a read enable
//   o_stat_cpu_stalls, o_stat_vga_forced  (ARB_STATS_EN only) event counters
module ram_arbiter #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_addr,
    input  logic [3:0]  i_cpu_sel,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_stall,
    input  logic        i_vga_req,
    input  logic [31:0] i_vga_addr,
    output logic        o_vga_gnt,
    output logic [31:0] o_vga_rdata,
    output logic        o_vga_rvalid,
    output logic        o_ram_en,
    output logic        o_ram_we,
    output logic [31:0] o_ram_addr,
    output logic [3:0]  o_ram_sel,
    output logic [31:0] o_ram_wdata,
    input  logic [31:0] i_ram_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [31:0] o_stat_cpu_stalls,
    output logic [31:0] o_stat_vga_forced
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};

    // Owner of the read issued in the previous cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_VGA  = 2'd2
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [31:0]       r_vga_hold;

    logic w_force;
    logic w_cpu_gnt;
    logic w_vga_gnt;
    logic w_cpu_stall;

    // Grant decision. Everything is gated by reset so that no RAM access
    // is issued while reset is asserted.
    always_comb begin
        w_force     = !i_rst && i_vga_req && (r_wait_cnt >= WAIT_LIMIT);
        w_cpu_gnt   = !i_rst && i_cpu_req && !w_force;
        w_vga_gnt   = !i_rst && i_vga_req && !w_cpu_gnt;
        w_cpu_stall = !i_rst && i_cpu_req && !w_cpu_gnt;
    end

    // RAM port mux
    always_comb begin
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_sel   = '0;
        o_ram_wdata = '0;
        if (w_cpu_gnt) begin
            o_ram_en    = 1'b1;
            o_ram_we    = i_cpu_we;
            o_ram_addr  = i_cpu_addr;
            o_ram_sel   = i_cpu_sel;
            o_ram_wdata = i_cpu_wdata;
        end else if (w_vga_gnt) begin
            o_ram_en    = 1'b1;
            o_ram_addr  = i_vga_addr;
            o_ram_sel   = 4'hF;
        end
    end

    assign o_cpu_stall = w_cpu_stall;
    assign o_vga_gnt   = w_vga_gnt;

    // Read return. VGA data passes through in its return cycle and is then
    // held, so the fetcher sees a stable value between returns.
    assign o_vga_rvalid = (r_state == S_VGA);
    assign o_vga_rdata  = (r_state == S_VGA) ? i_ram_rdata : r_vga_hold;
    assign o_cpu_rdata  = (r_state == S_CPU) ? i_ram_rdata : 32'h0;

    // Owner FSM, starvation counter and VGA data hold register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_vga_hold <= '0;
        end else begin
            if (r_state == S_VGA) begin
                r_vga_hold <= i_ram_rdata;
            end

            if (w_cpu_gnt && !i_cpu_we) begin
                r_state <= S_CPU;
            end else if (w_vga_gnt) begin
                r_state <= S_VGA;
            end else begin
                r_state <= S_IDLE;
            end

            if (!i_vga_req || w_vga_gnt) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_SAT) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_cpu_stalls;
    logic [31:0] r_stat_vga_forced;

    // Event counters; free-running and wrapping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_cpu_stalls <= '0;
            r_stat_vga_forced <= '0;
        end else begin
            if (w_cpu_stall) begin
                r_stat_cpu_stalls <= r_stat_cpu_stalls + 32'd1;
            end
            if (w_force && i_cpu_req) begin
                r_stat_vga_forced <= r_stat_vga_forced + 32'd1;
            end
        end
    end

    assign o_stat_cpu_stalls = r_stat_cpu_stalls;
    assign o_stat_vga_forced = r_stat_vga_forced;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a bench-side RAM, a cycle-level behavioural model
// of the arbitration rules, directed scenarios with literal expectations, and
// then randomized traffic with bursts of sustained contention.
module tb_ram_arbiter;

    localparam int unsigned MAX_WAIT = 8;
    localparam int unsigned SAT      = 255;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_sel;
    logic        cpu_stall;
    logic        vga_req;
    logic [31:0] vga_addr;
    logic        vga_gnt;
    logic [31:0] vga_rdata;
    logic        vga_rvalid;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_sel;
    logic [31:0] ram_rdata;
`ifdef ARB_STATS_EN
    logic [31:0] stat_cpu_stalls, stat_vga_forced;
`endif

    ram_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_sel   (cpu_sel),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_stall (cpu_stall),
        .i_vga_req   (vga_req),
        .i_vga_addr  (vga_addr),
        .o_vga_gnt   (vga_gnt),
        .o_vga_rdata (vga_rdata),
        .o_vga_rvalid(vga_rvalid),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_sel   (ram_sel),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
`ifdef ARB_STATS_EN
        ,
        .o_stat_cpu_stalls(stat_cpu_stalls),
        .o_stat_vga_forced(stat_vga_forced)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench RAM: 256 words, synchronous read with 1-cycle latency, byte-lane
    // writes. Refilled with a known pattern whenever reset is high.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) begin
                mem[k] <= (32'(k) * 32'h9E3779B9) ^ 32'h5A5A0000;
            end
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr[9:2]];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    int unsigned m_lost  = 0;    // consecutive denied VGA cycles
    int          m_owner = 0;    // 0 none, 1 cpu, 2 vga: read due this cycle
    logic [31:0] m_data  = '0;   // data due this cycle
    logic [31:0] m_vhold = '0;   // last VGA data delivered
    logic [31:0] m_stalls = '0;
    logic [31:0] m_forced = '0;

    // Compare every DUT output against the model for the current cycle, then
    // advance the model across the coming clock edge.
    task automatic model_step();
        logic frc, cg, vg, st;
        logic        e_en, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_sel;
        frc = !rst && vga_req && (m_lost >= MAX_WAIT);
        cg  = !rst && cpu_req && !frc;
        vg  = !rst && vga_req && !cg;
        st  = !rst && cpu_req && !cg;
        e_en = cg || vg;
        e_we = cg && cpu_we;
        e_addr  = cg ? cpu_addr  : (vg ? vga_addr : 32'h0);
        e_sel   = cg ? cpu_sel   : (vg ? 4'hF     : 4'h0);
        e_wdata = cg ? cpu_wdata : 32'h0;

        chk("cpu_stall",  32'(cpu_stall),  32'(st));
        chk("vga_gnt",    32'(vga_gnt),    32'(vg));
        chk("ram_en",     32'(ram_en),     32'(e_en));
        chk("ram_we",     32'(ram_we),     32'(e_we));
        chk("ram_addr",   ram_addr,        e_addr);
        chk("ram_sel",    32'(ram_sel),    32'(e_sel));
        chk("ram_wdata",  ram_wdata,       e_wdata);
        chk("vga_rvalid", 32'(vga_rvalid), 32'(m_owner == 2));
        chk("vga_rdata",  vga_rdata,       (m_owner == 2) ? m_data : m_vhold);
        chk("cpu_rdata",  cpu_rdata,       (m_owner == 1) ? m_data : 32'h0);
`ifdef ARB_STATS_EN
        chk("stat_cpu_stalls", stat_cpu_stalls, m_stalls);
        chk("stat_vga_forced", stat_vga_forced, m_forced);
`endif

        if (rst) begin
            m_lost = 0; m_owner = 0; m_vhold = '0; m_stalls = '0; m_forced = '0;
        end else begin
            if (m_owner == 2) m_vhold = m_data;
            if (!vga_req || vg) m_lost = 0;
            else if (m_lost < SAT) m_lost++;
            if (st) m_stalls = m_stalls + 32'd1;
            if (frc && cpu_req) m_forced = m_forced + 32'd1;
            if (cg && !cpu_we) begin
                m_owner = 1; m_data = mem[cpu_addr[9:2]];
            end else if (vg) begin
                m_owner = 2; m_data = mem[vga_addr[9:2]];
            end else begin
                m_owner = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_sel = 4'hF;
        cpu_wdata = '0; vga_req = 1'b1; vga_addr = '0;

        // Reset with both requests asserted
        repeat (2) @(negedge clk);
        #1 model_step();
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_stall",  32'(cpu_stall), 32'd0);
        chk("rst_vgagnt", 32'(vga_gnt), 32'd0);
        chk("rst_rvalid", 32'(vga_rvalid), 32'd0);

        @(negedge clk); rst = 1'b0; cpu_req = 1'b0; vga_req = 1'b0;
        #1 model_step();

        // Preload two words through the CPU write path
        @(negedge clk); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF;
        #1 model_step();
        @(negedge clk); cpu_addr = 32'h100; cpu_wdata = 32'hCAFEF00D;
        #1 model_step();

        // CPU read alone
        @(negedge clk); cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = '0;
        #1 model_step();
        chk("cpu_rd_addr",  ram_addr, 32'h40);
        chk("cpu_rd_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk); cpu_req = 1'b0;
        #1 model_step();
        chk("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);

        // VGA read alone
        @(negedge clk); vga_req = 1'b1; vga_addr = 32'h100;
        #1 model_step();
        chk("vga_rd_gnt", 32'(vga_gnt), 32'd1);
        chk("vga_rd_sel", 32'(ram_sel), 32'hF);
        @(negedge clk); vga_req = 1'b0;
        #1 model_step();
        chk("vga_rd_valid", 32'(vga_rvalid), 32'd1);
        chk("vga_rd_data",  vga_rdata, 32'hCAFEF00D);

        // Sustained contention; a CPU write lands on the forced VGA slot
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cpu_req = 1'b1; vga_req = 1'b1; cpu_addr = 32'h80; vga_addr = 32'h200;
            cpu_we  = (i == 8 || i == 9);
            cpu_sel = cpu_we ? 4'b0011 : 4'hF;
            cpu_wdata = 32'h1234_5678;
            #1 model_step();
            chk("cont_vga_gnt", 32'(vga_gnt),   32'(i == 8 || i == 17));
            chk("cont_stall",   32'(cpu_stall), 32'(i == 8 || i == 17));
            chk("cont_ram_we",  32'(ram_we),    32'(i == 9));
            if (i == 9) chk("cont_wr_sel", 32'(ram_sel), 32'h3);
            if (i == 10) begin
                chk("wr_no_rvalid", 32'(vga_rvalid), 32'd0);
                chk("wr_no_rdata",  cpu_rdata, 32'h0);
            end
        end

        // Reset arriving while a VGA read is being granted
        @(negedge clk); cpu_req = 1'b0; cpu_we = 1'b0; vga_req = 1'b1; vga_addr = 32'h100;
        #1 chk("mid_gnt", 32'(vga_gnt), 32'd1);
        #1 rst = 1'b1;
        #1 model_step();
        @(negedge clk); rst = 1'b0; vga_req = 1'b0;
        #1 model_step();
        chk("mid_rvalid", 32'(vga_rvalid), 32'd0);
`ifdef ARB_STATS_EN
        chk("mid_stat_stalls", stat_cpu_stalls, 32'd0);
        chk("mid_stat_forced", stat_vga_forced, 32'd0);
`endif

        // Randomized traffic with periodic full-contention bursts
        for (int c = 0; c < 4000; c++) begin
            logic burst;
            @(negedge clk);
            burst     = (c % 200) < 30;
            rst       = ($urandom_range(0, 299) == 0);
            cpu_req   = burst || ($urandom_range(0, 99) < 70);
            vga_req   = burst || ($urandom_range(0, 99) < 55);
            cpu_we    = ($urandom_range(0, 3) == 0);
            cpu_addr  = {22'd0, 8'($urandom), 2'b00};
            vga_addr  = {22'd0, 8'($urandom), 2'b00};
            cpu_sel   = 4'($urandom);
            cpu_wdata = $urandom;
            #1 model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
